prog_ctr_unit: RTL
==================

Name: prog_ctr_unit

Overview:
Program-counter and fetch-sequencing stage directly upstream of the instruction ROM. It drives the D-bit prog_ctr address that the ROM turns into a 9-bit mach_code combinationally.
- Handles start/halt sequencing, stalls, absolute and PC-relative branches, and wrap-around.
- Reports run status and a retired-instruction count to the testbench and top level.

Parameters:
D, 12, program-counter width; must match the instruction ROM address width.
START_ADDR, 0, address loaded on start.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset_n  input  1  synchronous reset, active low.
start  input  1  level or pulse; begins execution from START_ADDR.
halt_req  input  1  decoder flags the current instruction as HALT.
stall  input  1  hold the PC and all state this cycle.
branch_taken  input  1  the current instruction redirects the PC.
branch_rel  input  1  when branch_taken: 1 = relative, 0 = absolute.
target  input  D  absolute address, or two's-complement offset when relative.
prog_ctr  output  D  registered fetch address to the ROM.
running  output  1  high in state RUN.
done  output  1  high in state HALT; held until the next start or reset.
instr_count  output  CNT_W  instructions retired since the last start; saturating.

Behaviour:
- States: IDLE, RUN, HALT. Encoding is defined in the package. All outputs are registered.
- Reset (reset_n=0 at a clock edge, in any state, including mid-RUN):
  - state=IDLE, prog_ctr=0, running=0, done=0, instr_count=0.
  - Reset overrides every other input.
- IDLE:
  - start=1: go to RUN, prog_ctr=START_ADDR, instr_count=0.
  - Otherwise hold.
- RUN: one decision per cycle, in this priority order:
  1. stall=1: hold prog_ctr, instr_count and state. halt_req and branch are ignored this cycle.
  2. halt_req=1: go to HALT; prog_ctr holds the HALT address; instr_count+1. Halt wins over a simultaneous branch.
  3. branch_taken=1, branch_rel=0: prog_ctr=target; instr_count+1.
  4. branch_taken=1, branch_rel=1: prog_ctr=(prog_ctr + sign-extended target) mod 2^D; instr_count+1.
  5. Otherwise: prog_ctr=(prog_ctr+1) mod 2^D; instr_count+1.
  - start is ignored while in RUN.
- Wrap-around: 2^D-1 + 1 -> 0. Relative targets wrap the same way in both directions, e.g. 0 + (-1) -> 2^D-1. No error flag is raised.
- instr_count saturates at 2^CNT_W-1 and never wraps.
- HALT:
  - done=1, running=0; prog_ctr and instr_count are held for inspection.
  - start=1: go to RUN, prog_ctr=START_ADDR, instr_count=0, done=0 on the same edge.
- Latency: a new prog_ctr is visible one cycle after the controlling inputs are sampled. The ROM output follows combinationally in that same cycle.
- Control inputs (halt_req, branch_*, target, stall) are only meaningful in RUN and are ignored in IDLE/HALT.
- running and done are never both 1.

Decomposition:
- Package pc_pkg contains:
  - the state enum pc_state_t {IDLE, RUN, HALT};
  - the localparam default widths D_DEF=12 and CNT_W_DEF=16;
  - typedef pc_t = logic[D_DEF-1:0].
- One natural sub-module: pc_next_calc. It is purely combinational and takes prog_ctr, branch_taken, branch_rel, target. It returns the next sequential/branch address with sign extension and wrap.
- The FSM, counter and priority logic stay in prog_ctr_unit.

Test Plan:
1. Reset, then start=1 for one cycle, no branches, 5 cycles -> prog_ctr sequence 0,1,2,3,4,5; running=1; instr_count=5; done=0.
2. In RUN at prog_ctr=10: absolute branch target=200 -> next prog_ctr=200. Then relative branch target=-3 (12'hFFD) -> 197. Relative from 0 with target=-1 -> 4095.
3. Force prog_ctr to 4095 via an absolute branch, then a plain step -> 0. Drive stall=1 for 3 cycles mid-run -> prog_ctr and instr_count frozen. Also assert halt_req under stall -> no HALT entry.
4. At prog_ctr=7, assert halt_req and branch_taken together -> HALT, prog_ctr=7, done=1, running=0. Then start -> prog_ctr=0, instr_count=0, done=0.
5. Assert reset_n=0 for one cycle mid-RUN at prog_ctr=50 -> next edge prog_ctr=0, state IDLE, all outputs 0. Start ignored while reset_n=0.
6. Use CNT_W=4 and run 20 cycles -> instr_count saturates at 15. Pulse start during RUN -> no effect on prog_ctr.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default widths for the program-counter / fetch sequencer.
package pc_pkg;

    // Default program-counter width; matches the instruction ROM address width.
    localparam int D_DEF     = 12;
    // Default width of the retired-instruction counter.
    localparam int CNT_W_DEF = 16;

    // Fetch address at the default width.
    typedef logic [D_DEF-1:0] pc_t;

    // Sequencer states. Only these three encodings are legal. Any other value
    // is steered back to IDLE by the FSM.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } pc_state_t;

endpackage : pc_pkg

// File: rtl/pc_next_calc.sv
// Combinational next-address calculation.
// - Sequential step: pc + 1.
// - Absolute branch: target.
// - Relative branch: pc + sign-extended target.
// Every sum is taken modulo 2^D, so the address wraps silently in both directions.
module pc_next_calc #(
    parameter int D = 12
) (
    input  logic [D-1:0] pc_i,
    input  logic         branch_taken_i,
    input  logic         branch_rel_i,
    input  logic [D-1:0] target_i,
    output logic [D-1:0] next_pc_o
);

    // Increment used by the adder: +1 for a plain step, or the offset for a relative branch.
    logic [D-1:0] incr;
    // Result of the wrapping adder.
    logic [D-1:0] sum;

    // Choose the adder operand, then choose between the sum and an absolute target.
    // The offset has the same width as pc. A two's-complement add at width D is
    // therefore the sign-extended add reduced mod 2^D. No extra bits are needed,
    // and no carry or borrow is kept, because wrap-around is the intended behaviour.
    always_comb begin
        incr = D'(1);
        if (branch_taken_i && branch_rel_i) begin
            incr = target_i;
        end
        sum = pc_i + incr;

        if (branch_taken_i && !branch_rel_i) begin
            next_pc_o = target_i;
        end else begin
            next_pc_o = sum;
        end
    end

endmodule : pc_next_calc

// File: rtl/prog_ctr_unit.sv
// Program-counter and fetch sequencer that sits in front of the instruction ROM.
// - Runs a small IDLE / RUN / HALT FSM.
// - Handles stalls and branches, and keeps a saturating retired-instruction count.
// - All outputs are registered.
module prog_ctr_unit
    import pc_pkg::*;
#(
    parameter int          D          = D_DEF,
    parameter int unsigned START_ADDR = 0,
    parameter int          CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             branch_rel,
    input  logic [D-1:0]     target,
    output logic [D-1:0]     prog_ctr,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [D-1:0]     START_PC = D'(START_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    pc_state_t        state_q, state_d;
    logic [D-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    logic [D-1:0]     next_pc;
    logic [CNT_W-1:0] cnt_inc;

    // Address the fetch would move to if the current instruction retires normally.
    pc_next_calc #(
        .D (D)
    ) u_next (
        .pc_i           (pc_q),
        .branch_taken_i (branch_taken),
        .branch_rel_i   (branch_rel),
        .target_i       (target),
        .next_pc_o      (next_pc)
    );

    // Retired-instruction count plus one, held at its maximum instead of wrapping.
    always_comb begin
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // FSM and priority logic. In RUN the priority order is:
    // stall, then halt, then branch or step.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (stall) begin
                    // Hold everything. Halt and branch requests wait for a non-stalled cycle.
                    state_d = RUN;
                end else if (halt_req) begin
                    // Keep the HALT instruction's address visible for inspection.
                    state_d = HALT;
                    cnt_d   = cnt_inc;
                end else begin
                    pc_d  = next_pc;
                    cnt_d = cnt_inc;
                end
            end
            HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase

        // The status flags are decoded from the next state, so both flags are registered.
        // The two flags can never be high together.
        running_d = (state_d == RUN);
        done_d    = (state_d == HALT);
    end

    // State registers. The synchronous active-low reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign prog_ctr    = pc_q;
    assign running     = running_q;
    assign done        = done_q;
    assign instr_count = cnt_q;

endmodule : prog_ctr_unit
